// File: rtl/ball_motion.sv
// Ball kinematics: serve, per-frame step with wall/roof/paddle bounces, loss and re-serve.
// Optional SPEEDUP_EN: every 4th paddle hit raises both speeds by one, up to VMAX.
module ball_motion #(
  parameter int unsigned XMAX        = 159,
  parameter int unsigned YMAX        = 119,
  parameter int unsigned START_V     = 1,
  parameter int unsigned VMAX        = 4,
  parameter int unsigned SERVE_OFS   = 4,
  parameter int unsigned LOST_FRAMES = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [7:0] paddleX,
  input  logic [7:0] paddleY,
  input  logic       cX,
  input  logic       cY,
  output logic [7:0] ballX,
  output logic [7:0] ballY,
  output logic [2:0] vX,
  output logic [2:0] vY,
  output logic       dirX,
  output logic       dirY,
  output logic [1:0] state,
  output logic       ball_lost
);

  localparam int unsigned PW = 8;
  localparam int unsigned VW = 3;
  localparam int unsigned CW = $clog2(LOST_FRAMES);
  // Serve speed never exceeds the ceiling.
  localparam logic [VW-1:0] SERVE_V = VW'((START_V > VMAX) ? VMAX : START_V);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    LOST = 2'b10
  } state_t;

  state_t        stateQ, nextState;
  logic [PW-1:0] nextX, nextY;
  logic [VW-1:0] nextVX, nextVY;
  logic          nextDirX, nextDirY, nextLost;
  logic [CW-1:0] frameCnt, nextCnt;
  logic [PW:0]   sumX, sumY;
`ifdef SPEEDUP_EN
  logic [1:0]    hitCnt, nextHit;
`endif

  assign state = stateQ;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateQ    <= IDLE;
      ballX     <= PW'(80);
      ballY     <= PW'(100);
      vX        <= SERVE_V;
      vY        <= SERVE_V;
      dirX      <= 1'b1;
      dirY      <= 1'b0;
      ball_lost <= 1'b0;
      frameCnt  <= '0;
`ifdef SPEEDUP_EN
      hitCnt    <= '0;
`endif
    end else begin
      stateQ    <= nextState;
      ballX     <= nextX;
      ballY     <= nextY;
      vX        <= nextVX;
      vY        <= nextVY;
      dirX      <= nextDirX;
      dirY      <= nextDirY;
      ball_lost <= nextLost;
      frameCnt  <= nextCnt;
`ifdef SPEEDUP_EN
      hitCnt    <= nextHit;
`endif
    end
  end

  always_comb begin
    nextState = stateQ;
    nextX     = ballX;
    nextY     = ballY;
    nextVX    = vX;
    nextVY    = vY;
    nextDirX  = dirX;
    nextDirY  = dirY;
    nextLost  = 1'b0;
    nextCnt   = frameCnt;
    sumX      = '0;
    sumY      = '0;
`ifdef SPEEDUP_EN
    nextHit   = hitCnt;
`endif
    if (frame_tick) begin
      case (stateQ)
        IDLE: begin
          // Ball rides on the paddle until served.
          sumX  = {1'b0, paddleX} + (PW+1)'(SERVE_OFS);
          nextX = (sumX > (PW+1)'(XMAX)) ? PW'(XMAX) : sumX[PW-1:0];
          sumY  = {1'b0, paddleY} - (PW+1)'(1);
          nextY = sumY[PW] ? '0 : sumY[PW-1:0];
          if (launch) begin
            nextState = MOVE;
            nextVX    = SERVE_V;
            nextVY    = SERVE_V;
            nextDirX  = 1'b1;
            nextDirY  = 1'b0;
          end
        end
        MOVE: begin
          nextDirX = dirX ^ cX;
          nextDirY = dirY ^ cY;
`ifdef SPEEDUP_EN
          // Paddle hit: vertical bounce while descending.
          if (cY && dirY) begin
            nextHit = hitCnt + 2'd1;
            if (hitCnt == 2'd3) begin
              nextVX = (vX >= VW'(VMAX)) ? VW'(VMAX) : vX + VW'(1);
              nextVY = (vY >= VW'(VMAX)) ? VW'(VMAX) : vY + VW'(1);
            end
          end
`else
          nextVX = SERVE_V;
          nextVY = SERVE_V;
`endif
          if (nextDirX) begin
            sumX  = {1'b0, ballX} + {{(PW+1-VW){1'b0}}, nextVX};
            nextX = (sumX > (PW+1)'(XMAX)) ? PW'(XMAX) : sumX[PW-1:0];
          end else begin
            sumX  = {1'b0, ballX} - {{(PW+1-VW){1'b0}}, nextVX};
            nextX = sumX[PW] ? '0 : sumX[PW-1:0];
          end
          if (nextDirY) begin
            sumY  = {1'b0, ballY} + {{(PW+1-VW){1'b0}}, nextVY};
            nextY = sumY[PW] ? '1 : sumY[PW-1:0];
          end else begin
            sumY  = {1'b0, ballY} - {{(PW+1-VW){1'b0}}, nextVY};
            nextY = sumY[PW] ? '0 : sumY[PW-1:0];
          end
          if (nextY >= PW'(YMAX)) begin
            nextState = LOST;
            nextLost  = 1'b1;
            nextCnt   = '0;
          end
        end
        LOST: begin
          if (frameCnt == CW'(LOST_FRAMES - 1)) begin
            nextState = IDLE;
            nextCnt   = '0;
            nextVX    = SERVE_V;
            nextVY    = SERVE_V;
`ifdef SPEEDUP_EN
            nextHit   = '0;
`endif
          end else begin
            nextCnt = frameCnt + CW'(1);
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ball_motion;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       launch = 1'b0;
  logic [7:0] paddleX = '0;
  logic [7:0] paddleY = '0;
  logic       cX = 1'b0;
  logic       cY = 1'b0;
  logic [7:0] ballX, ballY;
  logic [2:0] vX, vY;
  logic       dirX, dirY;
  logic [1:0] state;
  logic       ball_lost;

  typedef struct {
    string      name;
    logic [7:0] bx;
    logic [7:0] by;
    logic [2:0] vx;
    logic [2:0] vy;
    logic       dx;
    logic       dy;
    logic [1:0] st;
    logic       lost;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  ball_motion dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .launch(launch),
    .paddleX(paddleX), .paddleY(paddleY), .cX(cX), .cY(cY),
    .ballX(ballX), .ballY(ballY), .vX(vX), .vY(vY), .dirX(dirX), .dirY(dirY),
    .state(state), .ball_lost(ball_lost)
  );

  always #5 clock = ~clock;

  task automatic pushExp(input string n, input int bx, input int by, input int vx, input int vy,
                         input int dx, input int dy, input int st, input int lost);
    exp_t e;
    e.name = n; e.bx = 8'(bx); e.by = 8'(by); e.vx = 3'(vx); e.vy = 3'(vy);
    e.dx = 1'(dx); e.dy = 1'(dy); e.st = 2'(st); e.lost = 1'(lost);
    expQ.push_back(e);
  endtask

  task automatic tick(input logic l, input logic x, input logic y);
    @(negedge clock);
    launch = l; cX = x; cY = y; frame_tick = 1'b1;
    @(posedge clock);
    #1;
    frame_tick = 1'b0; launch = 1'b0; cX = 1'b0; cY = 1'b0;
  endtask

  task automatic idleClk();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // Monitor: compares every outstanding expectation against the current outputs.
  always @(negedge clock) begin
    while (expQ.size() != 0) begin
      cur = expQ.pop_front();
      checks++;
      if ({ballX, ballY, vX, vY, dirX, dirY, state, ball_lost} !==
          {cur.bx, cur.by, cur.vx, cur.vy, cur.dx, cur.dy, cur.st, cur.lost}) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d vx=%0d vy=%0d dx=%0b dy=%0b st=%0d lost=%0b, expected x=%0d y=%0d vx=%0d vy=%0d dx=%0b dy=%0b st=%0d lost=%0b",
                 cur.name, ballX, ballY, vX, vY, dirX, dirY, state, ball_lost,
                 cur.bx, cur.by, cur.vx, cur.vy, cur.dx, cur.dy, cur.st, cur.lost);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    pushExp("reset", 80, 100, 1, 1, 1, 0, 0, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Serve position follows the paddle while idle
    paddleX = 8'd50; paddleY = 8'd110;
    tick(0, 0, 0);
    pushExp("idle_tick1", 54, 109, 1, 1, 1, 0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    pushExp("idle_tick3", 54, 109, 1, 1, 1, 0, 0, 0);
    tick(1, 0, 0);
    pushExp("launch_no_step", 54, 109, 1, 1, 1, 0, 1, 0);
    repeat (5) tick(0, 0, 0);
    pushExp("move_5_ticks", 59, 104, 1, 1, 1, 0, 1, 0);

    // Async reset mid-MOVE, and ticks ignored while held
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    pushExp("reset_mid_move", 80, 100, 1, 1, 1, 0, 0, 0);
    tick(1, 1, 1);
    pushExp("tick_in_reset", 80, 100, 1, 1, 1, 0, 0, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Right wall: serve clamps to XMAX, cX bounces off it
    paddleX = 8'd158; paddleY = 8'd50;
    tick(0, 0, 0);
    pushExp("serve_clamp_xmax", 159, 49, 1, 1, 1, 0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    pushExp("right_wall", 158, 48, 1, 1, 0, 0, 1, 0);

    // Left wall: underflow clamps to 0, cX bounces
    doReset();
    paddleX = 8'd0; paddleY = 8'd10;
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    pushExp("reach_left", 0, 5, 1, 1, 0, 0, 1, 0);
    tick(0, 0, 0);
    pushExp("left_clamp", 0, 4, 1, 1, 0, 0, 1, 0);
    tick(0, 1, 0);
    pushExp("left_wall", 1, 3, 1, 1, 1, 0, 1, 0);

    // Corner bounce at (10,0) moving up-left
    doReset();
    paddleX = 8'd8; paddleY = 8'd3;
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    pushExp("reach_corner", 10, 0, 1, 1, 0, 0, 1, 0);
    tick(0, 1, 1);
    pushExp("corner_bounce", 11, 1, 1, 1, 1, 1, 1, 0);

    // Fall to the bottom row, lose the ball, re-serve after 30 frames
    repeat (117) tick(0, 0, 0);
    pushExp("near_bottom", 128, 118, 1, 1, 1, 1, 1, 0);
    tick(0, 0, 0);
    pushExp("ball_lost", 129, 119, 1, 1, 1, 1, 2, 1);
    idleClk();
    pushExp("lost_pulse_end", 129, 119, 1, 1, 1, 1, 2, 0);
    repeat (29) tick(1, 1, 1);
    pushExp("lost_29_ticks", 129, 119, 1, 1, 1, 1, 2, 0);
    tick(0, 0, 0);
    pushExp("lost_to_idle", 129, 119, 1, 1, 1, 1, 0, 0);

    // Alternating roof/paddle bounces: each pair is one paddle hit
    paddleX = 8'd50; paddleY = 8'd60;
    tick(0, 0, 0);
    pushExp("reserve_pos", 54, 59, 1, 1, 1, 1, 0, 0);
    tick(1, 0, 0);
    repeat (8) tick(0, 0, 1);
`ifdef SPEEDUP_EN
    pushExp("hits_4", 63, 58, 2, 2, 1, 0, 1, 0);
`else
    pushExp("hits_4", 62, 59, 1, 1, 1, 0, 1, 0);
`endif
    repeat (24) tick(0, 0, 1);
`ifdef SPEEDUP_EN
    pushExp("hits_16", 137, 56, 4, 4, 1, 0, 1, 0);
`else
    pushExp("hits_16", 86, 59, 1, 1, 1, 0, 1, 0);
`endif

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", expQ.size());
      $fatal(1, "drain");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
